// File: rtl/fix_checksum_stream.sv
// FIX checksum generator/checker for a byte-lane message stream.
// Sums kept bytes mod 256, then either emits the checksum as three ASCII
// digits or compares it against a received 3-digit ASCII trailer.

// Per-lane byte gate: dropped lanes contribute zero to the beat sum.
module fix_cks_lane (
    input  logic [7:0] byte_i,
    input  logic       keep_i,
    output logic [7:0] byte_o
);
    assign byte_o = keep_i ? byte_i : 8'd0;
endmodule

module fix_checksum_stream #(
    parameter int BYTES_PER_BEAT = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [8*BYTES_PER_BEAT-1:0] data_i,
    input  logic [BYTES_PER_BEAT-1:0]   keep_i,
    input  logic                        valid_i,
    input  logic                        sop_i,
    input  logic                        eop_i,
    output logic                        ready_o,
    input  logic                        check_en_i,
    input  logic [23:0]                 expected_i,
    output logic [7:0]                  cks_data_o,
    output logic                        cks_valid_o,
    output logic                        cks_last_o,
    input  logic                        cks_ready_i,
    output logic [7:0]                  cks_bin_o,
    output logic                        result_vld_o,
    output logic                        match_o,
    output logic                        proto_err_o
);
    typedef enum logic [2:0] {IDLE, ACCUM, CONV, EMIT_H, EMIT_T, EMIT_U} state_t;

    state_t state, state_nxt;

    logic [BYTES_PER_BEAT-1:0][7:0] lane_bytes, lane_masked;
    logic [7:0]       beat_sum;
    logic [7:0]       sum;
    logic             chk_en_q;
    logic [23:0]      exp_q;
    logic [2:0][7:0]  dig_q;      // [2]=hundreds, [1]=tens, [0]=units, ASCII
    logic [1:0]       conv_h;
    logic [3:0]       conv_t, conv_u;
    logic [6:0]       conv_r;
    logic [23:0]      conv_ascii;
    logic             accept;

    assign lane_bytes = data_i;
    assign accept     = valid_i & ready_o;

    for (genvar g = 0; g < BYTES_PER_BEAT; g++) begin : g_lane
        fix_cks_lane u_lane (
            .byte_i (lane_bytes[g]),
            .keep_i (keep_i[g]),
            .byte_o (lane_masked[g])
        );
    end

    // Beat sum of the kept lanes, truncated to 8 bits.
    always_comb begin
        beat_sum = 8'd0;
        for (int i = 0; i < BYTES_PER_BEAT; i++)
            beat_sum = beat_sum + lane_masked[i];
    end

    // Binary 0..255 to three decimal digits, leading zeros kept.
    always_comb begin
        conv_h = 2'd0;
        conv_r = sum[6:0];
        if (sum >= 8'd200) begin
            conv_h = 2'd2;
            conv_r = 7'(sum - 8'd200);
        end else if (sum >= 8'd100) begin
            conv_h = 2'd1;
            conv_r = 7'(sum - 8'd100);
        end
        conv_t     = 4'(conv_r / 7'd10);
        conv_u     = 4'(conv_r - 7'(conv_t) * 7'd10);
        conv_ascii = {8'h30 + {6'd0, conv_h}, 8'h30 + {4'd0, conv_t}, 8'h30 + {4'd0, conv_u}};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and stream handshake outputs.
    always_comb begin
        state_nxt   = state;
        ready_o     = 1'b0;
        cks_valid_o = 1'b0;
        cks_last_o  = 1'b0;
        cks_data_o  = 8'd0;
        case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i && sop_i) state_nxt = eop_i ? CONV : ACCUM;
            end
            ACCUM: begin
                ready_o = 1'b1;
                if (valid_i && eop_i) state_nxt = CONV;
            end
            CONV: state_nxt = chk_en_q ? IDLE : EMIT_H;
            EMIT_H: begin
                cks_valid_o = 1'b1;
                cks_data_o  = dig_q[2];
                if (cks_ready_i) state_nxt = EMIT_T;
            end
            EMIT_T: begin
                cks_valid_o = 1'b1;
                cks_data_o  = dig_q[1];
                if (cks_ready_i) state_nxt = EMIT_U;
            end
            EMIT_U: begin
                cks_valid_o = 1'b1;
                cks_last_o  = 1'b1;
                cks_data_o  = dig_q[0];
                if (cks_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Accumulator, trailer/mode latches, conversion results and pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum          <= 8'd0;
            chk_en_q     <= 1'b0;
            exp_q        <= 24'd0;
            dig_q        <= '0;
            cks_bin_o    <= 8'd0;
            result_vld_o <= 1'b0;
            match_o      <= 1'b0;
            proto_err_o  <= 1'b0;
        end else begin
            result_vld_o <= 1'b0;
            match_o      <= 1'b0;
            proto_err_o  <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (sop_i) begin
                        sum      <= beat_sum;
                        chk_en_q <= check_en_i;
                        if (eop_i) exp_q <= expected_i;
                    end else begin
                        proto_err_o <= 1'b1;   // orphan beat, dropped
                    end
                end
                ACCUM: if (accept) begin
                    if (sop_i) begin
                        // New message aborts the current one.
                        sum         <= beat_sum;
                        chk_en_q    <= check_en_i;
                        proto_err_o <= 1'b1;
                    end else begin
                        sum <= sum + beat_sum;
                    end
                    if (eop_i) exp_q <= expected_i;
                end
                CONV: begin
                    cks_bin_o <= sum;
                    dig_q     <= conv_ascii;
                    if (chk_en_q) begin
                        result_vld_o <= 1'b1;
                        match_o      <= (exp_q == conv_ascii);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fix_checksum_stream.sv
// Directed table-driven bench for fix_checksum_stream (4 byte lanes).
module tb_fix_checksum_stream;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_i;
    logic [3:0]  keep_i;
    logic        valid_i, sop_i, eop_i, ready_o, check_en_i;
    logic [23:0] expected_i;
    logic [7:0]  cks_data_o, cks_bin_o;
    logic        cks_valid_o, cks_last_o, cks_ready_i;
    logic        result_vld_o, match_o, proto_err_o;

    int checks = 0;
    int errors = 0;

    fix_checksum_stream #(.BYTES_PER_BEAT(4)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .keep_i(keep_i),
        .valid_i(valid_i), .sop_i(sop_i), .eop_i(eop_i), .ready_o(ready_o),
        .check_en_i(check_en_i), .expected_i(expected_i),
        .cks_data_o(cks_data_o), .cks_valid_o(cks_valid_o), .cks_last_o(cks_last_o),
        .cks_ready_i(cks_ready_i), .cks_bin_o(cks_bin_o),
        .result_vld_o(result_vld_o), .match_o(match_o), .proto_err_o(proto_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              nb;
        logic [2:0][31:0] d;
        logic [2:0][3:0]  k;
        logic [7:0]       bin;
        logic [23:0]      txt;
    } vec_t;

    vec_t tv[7];

    function automatic vec_t mk(int nb, logic [31:0] d0, logic [3:0] k0, logic [31:0] d1,
                                logic [3:0] k1, logic [31:0] d2, logic [3:0] k2,
                                logic [7:0] bin, logic [23:0] txt);
        vec_t v;
        v.nb = nb;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
        v.k[0] = k0; v.k[1] = k1; v.k[2] = k2;
        v.bin = bin; v.txt = txt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic s,
                             input logic e, input logic ce, input logic [23:0] ex);
        chk("ready_before_beat", ready_o, 1);
        data_i = d; keep_i = k; sop_i = s; eop_i = e;
        check_en_i = ce; expected_i = ex; valid_i = 1'b1;
        tick;
        valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
    endtask

    task automatic send_msg(input vec_t v, input logic ce, input logic [23:0] ex);
        for (int b = 0; b < v.nb; b++)
            send_beat(v.d[b], v.k[b], b == 0, b == v.nb - 1, ce, ex);
    endtask

    // Called in the CONV cycle; drains the three digits with no backpressure.
    task automatic collect(input logic [23:0] txt, input logic [7:0] bin);
        chk("conv_valid", cks_valid_o, 0);
        chk("conv_ready", ready_o, 0);
        tick;
        cks_ready_i = 1'b1;
        for (int j = 0; j < 3; j++) begin
            chk("dig_valid", cks_valid_o, 1);
            chk("dig_data", cks_data_o, txt[23-8*j -: 8]);
            chk("dig_last", cks_last_o, (j == 2));
            chk("emit_ready", ready_o, 0);
            tick;
        end
        cks_ready_i = 1'b0;
        chk("post_ready", ready_o, 1);
        chk("post_valid", cks_valid_o, 0);
        chk("cks_bin", cks_bin_o, bin);
    endtask

    task automatic run_chk(input vec_t v, input logic [23:0] ex, input logic m);
        send_msg(v, 1'b1, ex);
        chk("chkmode_conv_rv", result_vld_o, 0);
        tick;
        chk("chkmode_rv", result_vld_o, 1);
        chk("chkmode_match", match_o, m);
        chk("chkmode_no_digit", cks_valid_o, 0);
        chk("chkmode_ready", ready_o, 1);
        chk("chkmode_bin", cks_bin_o, v.bin);
        tick;
        chk("chkmode_rv_pulse", result_vld_o, 0);
    endtask

    initial begin
        tv[0] = mk(3, 32'h41, 4'h1, 32'h42, 4'h1, 32'h01, 4'h1, 8'h84, 24'h313332);
        tv[1] = mk(3, 32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF, 4'hF, 32'h000000FF, 4'h1, 8'hF7, 24'h323437);
        tv[2] = mk(1, 32'hDEADBEEF, 4'h0, 0, 0, 0, 0, 8'h00, 24'h303030);
        tv[3] = mk(1, 32'hAA20AA10, 4'b0101, 0, 0, 0, 0, 8'h30, 24'h303438);
        tv[4] = mk(2, 32'h64646464, 4'hF, 32'hAA000037, 4'h1, 0, 0, 8'hC7, 24'h313939);
        tv[5] = mk(1, 32'h000000FF, 4'h1, 0, 0, 0, 0, 8'hFF, 24'h323535);
        tv[6] = mk(1, 32'h00000064, 4'h1, 0, 0, 0, 0, 8'h64, 24'h313030);

        rst = 1'b1; valid_i = 0; sop_i = 0; eop_i = 0; data_i = 0; keep_i = 0;
        check_en_i = 0; expected_i = 0; cks_ready_i = 0;
        tick; tick;
        chk("rst_ready", ready_o, 1);
        chk("rst_valid", cks_valid_o, 0);
        chk("rst_last", cks_last_o, 0);
        chk("rst_data", cks_data_o, 0);
        chk("rst_bin", cks_bin_o, 0);
        chk("rst_rv", result_vld_o, 0);
        chk("rst_match", match_o, 0);
        chk("rst_perr", proto_err_o, 0);
        rst = 1'b0;
        tick;

        // Generate mode over the whole table.
        for (int i = 0; i < 7; i++) begin
            send_msg(tv[i], 1'b0, 24'h0);
            collect(tv[i].txt, tv[i].bin);
        end

        // Check mode: matching and non-digit trailers.
        run_chk(tv[0], 24'h313332, 1'b1);
        run_chk(tv[0], 24'h313341, 1'b0);
        run_chk(tv[1], 24'h323437, 1'b1);

        // Backpressure: each digit stalled 5 cycles with a beat offered.
        send_msg(tv[1], 1'b0, 24'h0);
        tick;
        for (int j = 0; j < 3; j++) begin
            valid_i = 1'b1; sop_i = 1'b1; eop_i = 1'b1; data_i = 32'h11; keep_i = 4'h1;
            for (int s = 0; s < 5; s++) begin
                chk("stall_valid", cks_valid_o, 1);
                chk("stall_data", cks_data_o, tv[1].txt[23-8*j -: 8]);
                chk("stall_ready", ready_o, 0);
                tick;
            end
            valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
            chk("stall_last", cks_last_o, (j == 2));
            cks_ready_i = 1'b1;
            tick;
            cks_ready_i = 1'b0;
        end
        chk("stall_idle", ready_o, 1);
        chk("stall_bin", cks_bin_o, 8'hF7);
        chk("stall_perr", proto_err_o, 0);

        // Orphan beat in IDLE.
        send_beat(32'h55, 4'h1, 1'b0, 1'b0, 1'b0, 24'h0);
        chk("orphan_perr", proto_err_o, 1);
        tick;
        chk("orphan_perr_pulse", proto_err_o, 0);

        // sop mid-message: abort and restart, 5+7 = 12.
        send_beat(32'hFF, 4'h1, 1'b1, 1'b0, 1'b0, 24'h0);
        chk("accum_perr0", proto_err_o, 0);
        send_beat(32'h05, 4'h1, 1'b1, 1'b0, 1'b0, 24'h0);
        chk("restart_perr", proto_err_o, 1);
        send_beat(32'h07, 4'h1, 1'b0, 1'b1, 1'b0, 24'h0);
        chk("restart_perr_pulse", proto_err_o, 0);
        collect(24'h303132, 8'h0C);

        // Reset while emitting the tens digit.
        send_msg(tv[6], 1'b0, 24'h0);
        tick;
        cks_ready_i = 1'b1;
        tick;
        cks_ready_i = 1'b0;
        chk("pre_rst_tens", cks_data_o, 8'h30);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mid_rst_ready", ready_o, 1);
        chk("mid_rst_valid", cks_valid_o, 0);
        chk("mid_rst_last", cks_last_o, 0);
        chk("mid_rst_data", cks_data_o, 0);
        chk("mid_rst_bin", cks_bin_o, 0);
        chk("mid_rst_rv", result_vld_o, 0);
        chk("mid_rst_perr", proto_err_o, 0);

        // Recovery after reset.
        send_msg(tv[5], 1'b0, 24'h0);
        collect(tv[5].txt, tv[5].bin);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
